regfile_bypass: RTL

//  Parametrised CPU register file: NREGS x WIDTH storage, two read ports, one write port.
//  Top index (ZERO_REG) is hardwired zero, as LEGv8 XZR.

---
 rtl/regfile_bypass.sv | 67 ++++++
 1 files changed

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREGS x WIDTH register file, two read ports and one write port,
// with optional hardwired zero register, write->read bypass and registered reads.
module regfile_bypass #(
    parameter int WIDTH   = 64,
    parameter int NREGS   = 32,
    parameter bit ZERO_EN = 1'b1,
    parameter bit BYPASS  = 1'b1,
    parameter bit SYNC_RD = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(NREGS)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(NREGS)-1:0] i_rd_addr_a,
    input  logic [$clog2(NREGS)-1:0] i_rd_addr_b,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data_a,
    output logic [WIDTH-1:0]         o_rd_data_b
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_ADDR = '1;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_rd_a;
    logic [WIDTH-1:0] r_rd_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic             w_wr_ok;
    logic             w_zero_a;
    logic             w_zero_b;
    logic             w_byp_a;
    logic             w_byp_b;

    assign w_wr_ok = i_wr_en && !(ZERO_EN && i_wr_addr == ZERO_ADDR);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // zero register outranks bypass, so a write aimed at it never leaks through
    always_comb begin
        w_zero_a = ZERO_EN && i_rd_addr_a == ZERO_ADDR;
        w_zero_b = ZERO_EN && i_rd_addr_b == ZERO_ADDR;
        w_byp_a  = BYPASS && i_wr_en && i_wr_addr == i_rd_addr_a;
        w_byp_b  = BYPASS && i_wr_en && i_wr_addr == i_rd_addr_b;
        w_rd_a   = w_zero_a ? '0 : w_byp_a ? i_wr_data : r_regs[i_rd_addr_a];
        w_rd_b   = w_zero_b ? '0 : w_byp_b ? i_wr_data : r_regs[i_rd_addr_b];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else if (i_rd_en) begin
            r_rd_a <= w_rd_a;
            r_rd_b <= w_rd_b;
        end
    end

    assign o_rd_data_a = SYNC_RD ? r_rd_a : w_rd_a;
    assign o_rd_data_b = SYNC_RD ? r_rd_b : w_rd_b;
endmodule
